gpr_scoreboard: RTL and testbench
=================================

// Module: gpr_scoreboard
// PURPOSE
// - Issue-side hazard tracker feeding the dual-lane (upper/lower) pipeline that ends in writeback.
// - Records, per GPR, cycles left until writeback commits its pending result (ALU/load/FPU 1/2/4 clk).
// - Raises issue_stall on RAW/WAW hazards.
// - Freezes with the same global interlock that holds writeback.
// PARAMETERS
// - NREG     32  number of tracked GPRs (index width 5)
// - LAT_MAX  4   largest issue-to-writeback latency (fdiv); counter width CW = $clog2(LAT_MAX+1)
// PORTS
// - clk          in   1   clock
// - rstn         in   1   reset: asynchronous, active-low
// - interlock    in   1   global freeze, shared with writeback
// - u_valid      in   1   upper lane holds an instruction to issue
// - u_rt         in   5   upper destination register
// - u_lat        in   CW  upper latency to writeback; 0 = no GPR write
// - u_src_a/b    in   5   upper source registers
// - u_src_a/b_en in   1   upper source is actually read
// - l_*          in   ... identical lower-lane set: l_valid, l_rt, l_lat, l_src_a/b, l_src_a/b_en
// - issue_stall  out  1   bundle may not issue this cycle (combinational)
// - issue_fire   out  1   bundle accepted this cycle (combinational)
// - pending      out  32  bit r = count[r] != 0 (registered-state derived)
// BEHAVIOUR
// - State: count[0..NREG-1], CW bits each. All 32 registers tracked, r0 included.
// - Reset: all counts 0 immediately on rstn low, mid-operation included.
//   Outputs under reset: pending=0, issue_stall=0, issue_fire=0.
// - Hazard on a lane, valid=1 only:
//   - any enabled source with pending=1 (RAW); or
//   - lat!=0 and pending[rt]=1 (WAW).
// - Intra-bundle hazard, both valid:
//   - u_lat!=0 and l_rt==u_rt with l_lat!=0 (WAW); or
//   - u_lat!=0 and an enabled lower source == u_rt (RAW).
//   - Lower-to-upper dependence never counts.
// - issue_stall = any hazard.
// - issue_fire = (u_valid|l_valid) & ~issue_stall & ~interlock.
// - Bundle is atomic: both lanes issue or neither.
// - Each clk edge with interlock=0:
//   - every nonzero count decrements by 1;
//   - then, if issue_fire, count[rt] <= lat for each valid lane with lat!=0; set overrides decrement.
//   - Simultaneous set on the same register cannot occur (blocked by intra-bundle WAW).
// - Interlock=1:
//   - counts hold, nothing issues;
//   - issue_stall is still evaluated.
// - Timing: accept at edge E0 with lat=L -> pending high from E0 to E0+L, cleared by the edge on which writeback commits.
// - Boundaries:
//   - lat > LAT_MAX: clamp to LAT_MAX; assertion in simulation.
//   - lat=0: tracks nothing.
//   - count=1 and a new issue to that register: WAW stall (default build).
//   - valid=0 lanes: ignored entirely.
// CONFIGURATION
// - SCOREBOARD_EARLY_RELEASE_EN defined:
//   - RAW check ignores registers with count==1; the source is read after the committing edge.
//   - WAW on count==1 is allowed; the new lat overwrites.
// - Undefined: any count!=0 is a hazard (conservative, default).
// TESTING
// - Reset: rstn=0 mid-run with count[7]=3 -> pending=0, issue_stall=0 immediately; after release, src 7 issues at once.
// - RAW: upper rt=5 lat=2 fires at E0; next bundle reads r5 -> stall for cycles E0..E2, fire at E2+ (early-release build: fire one cycle sooner).
// - Interlock: rt=9 lat=4 fired, interlock=1 for 3 cycles -> count[9] holds at 3; pending[9] lasts 7 cycles total.
// - Intra-bundle: u_rt=3 lat=1, l_src_a=3 en -> stall until bundle splits.
//   - u_rt=3, l_rt=3, both lat!=0 -> stall.
//   - l_rt=3 with u_src_a=3 -> fires.
// - WAW: r12 pending (lat 4), new write to r12 lat 1 -> stall until pending[12]=0.
// - Clamp/none: u_lat=6 (LAT_MAX=4) -> count=4 plus sim assertion; lat=0 with rt=4 -> pending unchanged, fire=1.

Source files
------------

// File: rtl/gpr_scoreboard.sv
// Issue-side GPR hazard scoreboard for the dual-lane (upper/lower) pipeline.
// Optional build macro SCOREBOARD_EARLY_RELEASE_EN lets count==1 registers be read or rewritten.
module gpr_scoreboard #(
  parameter int NREG    = 32,
  parameter int LAT_MAX = 4,
  localparam int IW     = $clog2(NREG),
  localparam int CW     = $clog2(LAT_MAX + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            interlock,
  input  logic            u_valid,
  input  logic [IW-1:0]   u_rt,
  input  logic [CW-1:0]   u_lat,
  input  logic [IW-1:0]   u_src_a,
  input  logic [IW-1:0]   u_src_b,
  input  logic            u_src_a_en,
  input  logic            u_src_b_en,
  input  logic            l_valid,
  input  logic [IW-1:0]   l_rt,
  input  logic [CW-1:0]   l_lat,
  input  logic [IW-1:0]   l_src_a,
  input  logic [IW-1:0]   l_src_b,
  input  logic            l_src_a_en,
  input  logic            l_src_b_en,
  output logic            issue_stall,
  output logic            issue_fire,
  output logic [NREG-1:0] pending
);

  // Handshake: u_valid/l_valid offer one atomic bundle; issue_fire is its accept
  // strobe. While issue_fire is low the issuer must hold the bundle unchanged.

  logic [CW-1:0]   count     [NREG];
  logic [CW-1:0]   count_nxt [NREG];
  logic [NREG-1:0] busy;
  logic [CW-1:0]   u_lat_c;
  logic [CW-1:0]   l_lat_c;
  logic            u_haz;
  logic            l_haz;
  logic            intra_haz;
  logic            any_haz;

  assign u_lat_c = (u_lat > CW'(LAT_MAX)) ? CW'(LAT_MAX) : u_lat;
  assign l_lat_c = (l_lat > CW'(LAT_MAX)) ? CW'(LAT_MAX) : l_lat;

  // busy marks registers a new read or write must wait for
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pending[r] = (count[r] != '0);
`ifdef SCOREBOARD_EARLY_RELEASE_EN
      busy[r]    = (count[r] > CW'(1));
`else
      busy[r]    = (count[r] != '0);
`endif
    end
  end

  assign u_haz = u_valid & ((u_src_a_en & busy[u_src_a]) |
                            (u_src_b_en & busy[u_src_b]) |
                            ((u_lat != '0) & busy[u_rt]));
  assign l_haz = l_valid & ((l_src_a_en & busy[l_src_a]) |
                            (l_src_b_en & busy[l_src_b]) |
                            ((l_lat != '0) & busy[l_rt]));

  // Only the lower lane can depend on the upper lane within one bundle
  assign intra_haz = u_valid & l_valid & (u_lat != '0) &
                     (((l_lat != '0) & (l_rt == u_rt)) |
                      (l_src_a_en & (l_src_a == u_rt)) |
                      (l_src_b_en & (l_src_b == u_rt)));

  assign any_haz     = u_haz | l_haz | intra_haz;
  assign issue_stall = rstn & any_haz;
  assign issue_fire  = rstn & (u_valid | l_valid) & ~any_haz & ~interlock;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      count_nxt[r] = pending[r] ? (count[r] - CW'(1)) : '0;
      if (issue_fire && u_valid && (u_lat_c != '0) && (u_rt == IW'(r)))
        count_nxt[r] = u_lat_c;
      if (issue_fire && l_valid && (l_lat_c != '0) && (l_rt == IW'(r)))
        count_nxt[r] = l_lat_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
    end else if (!interlock) begin
      for (int r = 0; r < NREG; r++) count[r] <= count_nxt[r];
    end
  end

  // Out-of-range latencies are clamped above; flag them so the issuer gets fixed
  always_comb begin
    if (u_valid) assert (u_lat <= CW'(LAT_MAX)) else $warning("gpr_scoreboard: u_lat above LAT_MAX, clamped");
    if (l_valid) assert (l_lat <= CW'(LAT_MAX)) else $warning("gpr_scoreboard: l_lat above LAT_MAX, clamped");
  end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Bench for gpr_scoreboard: vector table, multi-cycle corner sequences and
// randomized bundles against a per-register countdown model.
module tb_gpr_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rt;
    logic [2:0] lat;
    logic [4:0] a;
    logic       ae;
    logic [4:0] b;
    logic       be;
  } lane_t;

  typedef struct packed {
    lane_t       u;
    lane_t       l;
    logic        stall;
    logic        fire;
    logic [31:0] pend;
  } vec_t;

`ifdef SCOREBOARD_EARLY_RELEASE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        interlock = 1'b0;
  lane_t       u_in = '0;
  lane_t       l_in = '0;
  logic        issue_stall;
  logic        issue_fire;
  logic [31:0] pending;

  int   total = 0;
  int   bad = 0;
  int   cnt [32];
  vec_t vecs[$];

  gpr_scoreboard dut (
    .clk(clk), .rstn(rstn), .interlock(interlock),
    .u_valid(u_in.v), .u_rt(u_in.rt), .u_lat(u_in.lat),
    .u_src_a(u_in.a), .u_src_b(u_in.b), .u_src_a_en(u_in.ae), .u_src_b_en(u_in.be),
    .l_valid(l_in.v), .l_rt(l_in.rt), .l_lat(l_in.lat),
    .l_src_a(l_in.a), .l_src_b(l_in.b), .l_src_a_en(l_in.ae), .l_src_b_en(l_in.be),
    .issue_stall(issue_stall), .issue_fire(issue_fire), .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // reference model: remaining cycles until writeback, per register
  function automatic bit busy(int r);
    return EARLY ? (cnt[r] > 1) : (cnt[r] != 0);
  endfunction

  function automatic bit lane_haz(lane_t ln);
    if (!ln.v) return 1'b0;
    return (ln.ae && busy(int'(ln.a))) || (ln.be && busy(int'(ln.b))) ||
           (ln.lat != 0 && busy(int'(ln.rt)));
  endfunction

  function automatic bit exp_stall();
    bit intra;
    if (!rstn) return 1'b0;
    intra = u_in.v && l_in.v && u_in.lat != 0 &&
            ((l_in.lat != 0 && l_in.rt == u_in.rt) ||
             (l_in.ae && l_in.a == u_in.rt) || (l_in.be && l_in.b == u_in.rt));
    return lane_haz(u_in) || lane_haz(l_in) || intra;
  endfunction

  function automatic bit exp_fire();
    return rstn && (u_in.v || l_in.v) && !exp_stall() && !interlock;
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] p;
    for (int r = 0; r < 32; r++) p[r] = (cnt[r] != 0);
    return p;
  endfunction

  task automatic model_edge(bit f);
    if (!rstn || interlock) return;
    for (int r = 0; r < 32; r++) if (cnt[r] > 0) cnt[r]--;
    if (f) begin
      if (u_in.v && u_in.lat != 0) cnt[u_in.rt] = (u_in.lat > 4) ? 4 : int'(u_in.lat);
      if (l_in.v && l_in.lat != 0) cnt[l_in.rt] = (l_in.lat > 4) ? 4 : int'(l_in.lat);
    end
  endtask

  // driver tasks
  function automatic lane_t mk(int v, int rt, int lat, int a, int ae, int b, int be);
    lane_t x;
    x.v = v[0]; x.rt = rt[4:0]; x.lat = lat[2:0];
    x.a = a[4:0]; x.ae = ae[0]; x.b = b[4:0]; x.be = be[0];
    return x;
  endfunction

  task automatic drive(lane_t u, lane_t l, bit il);
    u_in = u;
    l_in = l;
    interlock = il;
  endtask

  // one clock: model follows the edge; returns at the next falling edge
  task automatic tick();
    bit f;
    f = exp_fire();
    @(posedge clk);
    model_edge(f);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    drive('0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // scoreboard
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(lane_t u, lane_t l, bit s, bit f, logic [31:0] p);
    vec_t v;
    v.u = u; v.l = l; v.stall = s; v.fire = f; v.pend = p;
    vecs.push_back(v);
  endtask

  initial begin
    int nst;
    int np;
    bit fired;

    // single-bundle cases, each applied to an empty scoreboard
    add_vec(mk(1, 3, 1, 0, 0, 0, 0), mk(1, 8, 0, 3, 1, 0, 0), 1'b1, 1'b0, 32'h0);
    add_vec(mk(1, 3, 1, 0, 0, 0, 0), mk(1, 3, 2, 0, 0, 0, 0), 1'b1, 1'b0, 32'h0);
    add_vec(mk(1, 7, 2, 3, 1, 0, 0), mk(1, 3, 1, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0088);
    add_vec(mk(1, 4, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0);
    add_vec(mk(1, 10, 6, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0400);
    add_vec(mk(0, 3, 1, 3, 1, 0, 0), mk(0, 3, 2, 3, 1, 0, 0), 1'b0, 1'b0, 32'h0);
    add_vec(mk(0, 3, 1, 0, 0, 0, 0), mk(1, 8, 2, 3, 1, 0, 0), 1'b0, 1'b1, 32'h0000_0100);
    add_vec(mk(1, 3, 0, 0, 0, 0, 0), mk(1, 9, 4, 3, 1, 0, 0), 1'b0, 1'b1, 32'h0000_0200);
    add_vec(mk(1, 3, 1, 0, 0, 0, 0), mk(1, 11, 0, 0, 0, 3, 0), 1'b0, 1'b1, 32'h0000_0008);
    add_vec(mk(1, 0, 2, 0, 0, 0, 0), mk(1, 1, 1, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0003);
    add_vec(mk(0, 0, 0, 0, 0, 0, 0), mk(1, 31, 3, 30, 1, 29, 1), 1'b0, 1'b1, 32'h8000_0000);
    add_vec(mk(1, 5, 3, 5, 1, 5, 1), mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0020);

    for (int r = 0; r < 32; r++) cnt[r] = 0;

    // outputs held low in reset even with a hazardous bundle offered
    drive(mk(1, 3, 1, 0, 0, 0, 0), mk(1, 3, 2, 3, 1, 0, 0), 1'b0);
    @(negedge clk);
    #1;
    check("rst_stall", 32'(issue_stall), 32'h0);
    check("rst_fire", 32'(issue_fire), 32'h0);
    check("rst_pending", pending, 32'h0);

    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].u, vecs[i].l, 1'b0);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(issue_stall), 32'(vecs[i].stall));
      check($sformatf("vec%0d_fire", i), 32'(issue_fire), 32'(vecs[i].fire));
      tick();
      #1;
      check($sformatf("vec%0d_pending", i), pending, vecs[i].pend);
    end

    // asynchronous reset mid-run with r7 still three cycles out
    do_reset();
    drive(mk(1, 7, 3, 0, 0, 0, 0), '0, 1'b0);
    #1;
    check("seqa_issue", 32'(issue_fire), 32'h1);
    tick();
    drive(mk(1, 2, 1, 7, 1, 0, 0), '0, 1'b0);
    #1;
    check("seqa_raw", 32'(issue_stall), 32'h1);
    #2;
    rstn = 1'b0;
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    #1;
    check("seqa_rst_pending", pending, 32'h0);
    check("seqa_rst_stall", 32'(issue_stall), 32'h0);
    check("seqa_rst_fire", 32'(issue_fire), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("seqa_post_stall", 32'(issue_stall), 32'h0);
    check("seqa_post_fire", 32'(issue_fire), 32'h1);
    tick();

    // RAW on r5 (lat 2)
    do_reset();
    drive(mk(1, 5, 2, 0, 0, 0, 0), '0, 1'b0);
    #1;
    check("seqb_issue", 32'(issue_fire), 32'h1);
    tick();
    drive(mk(1, 6, 1, 5, 1, 0, 0), '0, 1'b0);
    nst = 0;
    fired = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (issue_fire) begin
        fired = 1'b1;
        break;
      end
      nst++;
      tick();
    end
    check("seqb_fired", 32'(fired), 32'h1);
    check("seqb_stall_cycles", nst, EARLY ? 1 : 2);
    tick();
    #1;
    check("seqb_pend6", 32'(pending[6]), 32'h1);

    // interlock freezes r9 countdown for three cycles
    do_reset();
    drive(mk(1, 9, 4, 0, 0, 0, 0), '0, 1'b0);
    #1;
    check("seqc_issue", 32'(issue_fire), 32'h1);
    tick();
    np = 0;
    drive('0, '0, 1'b0);
    #1;
    if (pending[9]) np++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 2, 1, 9, 1, 0, 0), '0, 1'b1);
      #1;
      if (i == 0) begin
        check("seqc_il_stall", 32'(issue_stall), 32'h1);
        check("seqc_il_fire", 32'(issue_fire), 32'h0);
      end
      if (pending[9]) np++;
      tick();
    end
    drive('0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (pending[9]) np++;
      tick();
    end
    check("seqc_pend_cycles", np, 7);

    // WAW on r12: lat 4 outstanding, new lat 1 write waits
    do_reset();
    drive(mk(1, 12, 4, 0, 0, 0, 0), '0, 1'b0);
    #1;
    check("seqd_issue", 32'(issue_fire), 32'h1);
    tick();
    drive(mk(1, 12, 1, 0, 0, 0, 0), '0, 1'b0);
    nst = 0;
    fired = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (issue_fire) begin
        fired = 1'b1;
        break;
      end
      nst++;
      tick();
    end
    check("seqd_fired", 32'(fired), 32'h1);
    check("seqd_stall_cycles", nst, EARLY ? 3 : 4);
    tick();
    drive('0, '0, 1'b0);
    #1;
    check("seqd_pend12_set", 32'(pending[12]), 32'h1);
    tick();
    #1;
    check("seqd_pend12_clr", 32'(pending[12]), 32'h0);

    // lat 6 clamps to 4 cycles of pending
    do_reset();
    drive(mk(1, 10, 6, 0, 0, 0, 0), '0, 1'b0);
    #1;
    check("seqe_issue", 32'(issue_fire), 32'h1);
    tick();
    drive('0, '0, 1'b0);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (pending[10]) np++;
      tick();
    end
    check("seqe_clamp_cycles", np, 4);

    // randomized bundles on a small register window so hazards are frequent
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lane_t ru;
      lane_t rl;
      ru = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 4),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
      rl = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 4),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
      drive(ru, rl, ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      #1;
      check("rnd_stall", 32'(issue_stall), 32'(exp_stall()));
      check("rnd_fire", 32'(issue_fire), 32'(exp_fire()));
      check("rnd_pending", pending, exp_pend());
      tick();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
